mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter DW, default 32, SHALL be the data/address width; legal values are 32 and 64.
REQ-002 Parameter NB, default DW/8, SHALL be the byte-lane count; it is derived and SHALL NOT be overridden.
REQ-003 Ports SHALL be (name direction width meaning):
- clk in 1: single clock; all state on rising edge.
- rst in 1: synchronous, active-high reset.
- ex_to_mem_valid in 1 / o_mem_ready out 1: upstream handshake.
- mem_to_wb_valid out 1 / i_wb_ready in 1: downstream handshake.
- in_ld, in_st in 1: load / store op (mutually exclusive).
- in_size in 2: 0 byte, 1 half, 2 word, 3 dword.
- in_unsigned in 1: zero-extend load when 1, else sign-extend.
- in_alu_res in DW: address (mem op) or result (non-mem op).
- in_st_data in DW: store source.
- in_rf_waddr in 5, in_rf_we in 1, in_pc in 32, in_inst in 32: sideband.
- req out 1, req_wr out 1, req_wstrb out NB, req_addr out DW, req_wdata out DW: data-SRAM request.
- addr_ok in 1, data_ok in 1, rdata in DW: SRAM responses.
- mem_to_wb_rf_wdata out DW, mem_to_wb_rf_waddr out 5, mem_to_wb_rf_we out 1, mem_to_wb_pc out 32, mem_to_wb_inst out 32.
- mem_to_wb_mem_re out 1: held op is a load (bypass stall hint).
- mem_busy out 1: high in REQ or WAIT.

Function
REQ-004 FSM states SHALL be IDLE, REQ, WAIT, HOLD.
REQ-005 o_mem_ready SHALL equal (state==IDLE) | (state==HOLD & i_wb_ready); accept = ex_to_mem_valid & o_mem_ready.
REQ-006 On accept all inputs SHALL be registered; next state is REQ for ld/st, HOLD otherwise.
REQ-007 On HOLD & i_wb_ready without accept, next state SHALL be IDLE.
REQ-008 In REQ, req SHALL be 1 with stable fields; addr_ok moves to WAIT.
REQ-009 In WAIT, data_ok SHALL move to HOLD; a load captures extracted rdata into the result register.
REQ-010 data_ok SHALL be ignored outside WAIT; addr_ok SHALL be ignored outside REQ.
REQ-011 mem_to_wb_valid SHALL be 1 only in HOLD; outputs SHALL stay stable while HOLD & !i_wb_ready.
REQ-012 Latency accept->valid SHALL be 1 cycle for non-mem ops, and 3 cycles minimum for ld/st (addr_ok in first REQ cycle, data_ok first WAIT cycle).
REQ-013 lane = req_addr[log2(NB)-1:0]; bytes = 1<<in_size, with size 3 treated as 2 when DW=32.
REQ-014 req_wstrb SHALL be ((1<<bytes)-1)<<lane for stores and 0 for loads; req_wr = in_st.
REQ-015 req_wdata SHALL be the low bytes*8 bits of in_st_data replicated across DW.
REQ-016 Load data SHALL be rdata>>(lane*8), truncated to bytes*8 bits, then zero/sign-extended to DW per in_unsigned.
REQ-017 mem_to_wb_rf_wdata SHALL be the extracted load data for loads and the registered in_alu_res otherwise.
REQ-018 Stores SHALL output mem_to_wb_rf_we=0 regardless of in_rf_we.
REQ-019 mem_to_wb_mem_re SHALL be 1 when the held/in-flight op is a load.

Reset
REQ-020 rst SHALL force IDLE and set req, mem_to_wb_valid, mem_to_wb_rf_we, mem_to_wb_mem_re, and mem_busy to 0; data registers SHALL be 0.
REQ-021 rst in REQ/WAIT SHALL abandon the access; any later data_ok SHALL be ignored.

Configuration
REQ-022 With MEM_ALE_EN defined, output mem_to_wb_ale (1 bit) SHALL exist; a ld/st with addr not aligned to bytes skips REQ/WAIT, goes to HOLD in 1 cycle, issues no req, and has ale=1 and rf_we=0.
REQ-023 Without MEM_ALE_EN, the port SHALL be absent and misaligned accesses proceed using the lane shift, with bytes crossing DW truncated.

Verification
REQ-024 DW=32: ld.b unsigned=0, addr 0x1003, rdata 0x80112233 -> req_wstrb 0, wdata 0xFFFFFF80, valid 3 cycles after accept.
REQ-025 DW=32: st.h addr 0x2002, st_data 0x0000BEEF -> req_wstrb 4'b1100, req_wdata 0xBEEFBEEF, rf_we 0.
REQ-026 DW=64: ld.w unsigned=1, addr 0x...4, rdata 0xDEADBEEF_00000000 -> wdata 0x00000000DEADBEEF.
REQ-027 ALU op with i_wb_ready=0 for 4 cycles -> valid held, o_mem_ready 0, outputs stable; release -> back-to-back accept same cycle.
REQ-028 rst asserted in WAIT then data_ok pulse -> IDLE, no valid, req 0.
REQ-029 MEM_ALE_EN: ld.w addr 0x1002 -> no req, valid after 1 cycle, ale 1, rf_we 0.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: memory stage load/store unit with a valid/ready pipeline handshake
// and an addr_ok/data_ok data-SRAM request interface.
// Optional feature: define MEM_ALE_EN to add mem_to_wb_ale and to skip the
// SRAM access for misaligned loads/stores (flagged instead of issued).
// NB is derived from DW and must not be overridden.
module mem_lsu #(
  parameter int DW = 32,
  parameter int NB = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_to_mem_valid,
  output logic          o_mem_ready,
  output logic          mem_to_wb_valid,
  input  logic          i_wb_ready,
  input  logic          in_ld,
  input  logic          in_st,
  input  logic [1:0]    in_size,
  input  logic          in_unsigned,
  input  logic [DW-1:0] in_alu_res,
  input  logic [DW-1:0] in_st_data,
  input  logic [4:0]    in_rf_waddr,
  input  logic          in_rf_we,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_inst,
  output logic          req,
  output logic          req_wr,
  output logic [NB-1:0] req_wstrb,
  output logic [DW-1:0] req_addr,
  output logic [DW-1:0] req_wdata,
  input  logic          addr_ok,
  input  logic          data_ok,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] mem_to_wb_rf_wdata,
  output logic [4:0]    mem_to_wb_rf_waddr,
  output logic          mem_to_wb_rf_we,
  output logic [31:0]   mem_to_wb_pc,
  output logic [31:0]   mem_to_wb_inst,
  output logic          mem_to_wb_mem_re,
`ifdef MEM_ALE_EN
  output logic          mem_to_wb_ale,
`endif
  output logic          mem_busy
);

  localparam int LW = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

  state_e state_q, state_d;

  logic          ld_q, st_q, unsigned_q, rf_we_q;
  logic [1:0]    size_q;
  logic [DW-1:0] alu_res_q, st_data_q, result_q;
  logic [4:0]    rf_waddr_q;
  logic [31:0]   pc_q, inst_q;

  logic          accept, in_mem_op, skip_mem;
  logic [LW-1:0] lane;
  logic [1:0]    sz;
  logic [DW-1:0] shifted, ld_data;
  logic [NB-1:0] strb_base;

  // A dword access has no meaning on a 32-bit datapath; it behaves as a word.
  function automatic logic [1:0] eff_size(input logic [1:0] s);
    if (DW == 32 && s == 2'd3) return 2'd2;
    return s;
  endfunction

  assign accept    = ex_to_mem_valid & o_mem_ready;
  assign in_mem_op = in_ld | in_st;
  assign lane      = alu_res_q[LW-1:0];
  assign sz        = eff_size(size_q);

`ifdef MEM_ALE_EN
  logic ale_q;
  logic in_misalign;

  // Alignment check of the incoming address against its access size.
  always_comb begin
    in_misalign = 1'b0;
    case (eff_size(in_size))
      2'd1:    in_misalign = in_alu_res[0];
      2'd2:    in_misalign = |in_alu_res[1:0];
      2'd3:    in_misalign = |in_alu_res[2:0];
      default: in_misalign = 1'b0;
    endcase
  end
  assign skip_mem = in_misalign;
`else
  assign skip_mem = 1'b0;
`endif

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (accept)                              state_d = (in_mem_op && !skip_mem) ? S_REQ : S_HOLD;
        else if (state_q == S_HOLD && i_wb_ready) state_d = S_IDLE;
      end
      S_REQ:   if (addr_ok) state_d = S_WAIT;
      S_WAIT:  if (data_ok) state_d = S_HOLD;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture on accept, load-result capture on the data response.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      ld_q       <= 1'b0;
      st_q       <= 1'b0;
      unsigned_q <= 1'b0;
      rf_we_q    <= 1'b0;
      size_q     <= '0;
      alu_res_q  <= '0;
      st_data_q  <= '0;
      result_q   <= '0;
      rf_waddr_q <= '0;
      pc_q       <= '0;
      inst_q     <= '0;
`ifdef MEM_ALE_EN
      ale_q      <= 1'b0;
`endif
    end else if (accept) begin
      ld_q       <= in_ld;
      st_q       <= in_st;
      unsigned_q <= in_unsigned;
      rf_we_q    <= in_rf_we;
      size_q     <= in_size;
      alu_res_q  <= in_alu_res;
      st_data_q  <= in_st_data;
      result_q   <= '0;
      rf_waddr_q <= in_rf_waddr;
      pc_q       <= in_pc;
      inst_q     <= in_inst;
`ifdef MEM_ALE_EN
      ale_q      <= in_mem_op & in_misalign;
`endif
    end else if (state_q == S_WAIT && data_ok && ld_q) begin
      result_q <= ld_data;
    end
  end

  // Load data alignment: shift the addressed lane down, then zero/sign-extend.
  always_comb begin
    shifted = rdata >> {lane, 3'b000};
    ld_data = shifted;
    case (sz)
      2'd0: begin
        ld_data      = {DW{~unsigned_q & shifted[7]}};
        ld_data[7:0] = shifted[7:0];
      end
      2'd1: begin
        ld_data       = {DW{~unsigned_q & shifted[15]}};
        ld_data[15:0] = shifted[15:0];
      end
      2'd2: begin
        ld_data       = {DW{~unsigned_q & shifted[31]}};
        ld_data[31:0] = shifted[31:0];
      end
      default: ld_data = shifted;
    endcase
  end

  // Handshake, SRAM request and writeback outputs.
  always_comb begin
    o_mem_ready     = (state_q == S_IDLE) | ((state_q == S_HOLD) & i_wb_ready);
    mem_to_wb_valid = (state_q == S_HOLD);
    req             = (state_q == S_REQ);
    mem_busy        = (state_q == S_REQ) | (state_q == S_WAIT);
    req_wr          = st_q;
    req_addr        = alu_res_q;

    case (sz)
      2'd0:    strb_base = NB'(1'b1);
      2'd1:    strb_base = NB'(2'b11);
      2'd2:    strb_base = NB'(4'hF);
      default: strb_base = '1;
    endcase
    // Lanes shifted past the top of the bus are dropped.
    req_wstrb = st_q ? (strb_base << lane) : '0;

    req_wdata = '0;
    for (int i = 0; i < NB; i++) begin
      case (sz)
        2'd0:    req_wdata[i*8 +: 8] = st_data_q[7:0];
        2'd1:    req_wdata[i*8 +: 8] = st_data_q[(i % 2)*8 +: 8];
        2'd2:    req_wdata[i*8 +: 8] = st_data_q[(i % 4)*8 +: 8];
        default: req_wdata[i*8 +: 8] = st_data_q[i*8 +: 8];
      endcase
    end

    mem_to_wb_rf_wdata = ld_q ? result_q : alu_res_q;
    mem_to_wb_rf_waddr = rf_waddr_q;
    mem_to_wb_pc       = pc_q;
    mem_to_wb_inst     = inst_q;
    mem_to_wb_mem_re   = ld_q;
`ifdef MEM_ALE_EN
    mem_to_wb_ale      = ale_q;
    mem_to_wb_rf_we    = rf_we_q & ~st_q & ~ale_q;
`else
    mem_to_wb_rf_we    = rf_we_q & ~st_q;
`endif
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed bench for mem_lsu with a 32-bit and a 64-bit instance.
// Expected writeback results go into a scoreboard queue at issue time and are
// popped when the DUT presents mem_to_wb_valid. Define MEM_ALE_EN for both
// bench and RTL to exercise the misaligned-access flag.
module tb_mem_lsu;

  typedef struct {
    logic [63:0] wdata;
    logic        we;
    logic        mem_re;
  } exp_t;

  exp_t sb32[$];
  exp_t sb64[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 32-bit instance signals
  logic        ex_to_mem_valid, o_mem_ready, mem_to_wb_valid, i_wb_ready;
  logic        in_ld, in_st, in_unsigned, in_rf_we;
  logic [1:0]  in_size;
  logic [31:0] in_alu_res, in_st_data, in_pc, in_inst;
  logic [4:0]  in_rf_waddr, mem_to_wb_rf_waddr;
  logic        req, req_wr, addr_ok, data_ok;
  logic [3:0]  req_wstrb;
  logic [31:0] req_addr, req_wdata, rdata;
  logic [31:0] mem_to_wb_rf_wdata, mem_to_wb_pc, mem_to_wb_inst;
  logic        mem_to_wb_rf_we, mem_to_wb_mem_re, mem_busy;

  // 64-bit instance signals
  logic        w_ex_valid, w_ready, w_valid, w_wb_ready;
  logic        w_ld, w_st, w_uns, w_we;
  logic [1:0]  w_size;
  logic [63:0] w_alu, w_sdata, w_addr, w_wdata, w_rdata, w_rf_wdata;
  logic [31:0] w_pc, w_inst, w_wb_pc, w_wb_inst;
  logic [4:0]  w_waddr, w_rf_waddr;
  logic        w_req, w_req_wr, w_addr_ok, w_data_ok;
  logic [7:0]  w_wstrb;
  logic        w_rf_we, w_mem_re, w_busy;

`ifdef MEM_ALE_EN
  logic mem_to_wb_ale, w_ale;
`endif

  mem_lsu #(.DW(32)) dut32 (
    .clk(clk), .rst(rst),
    .ex_to_mem_valid(ex_to_mem_valid), .o_mem_ready(o_mem_ready),
    .mem_to_wb_valid(mem_to_wb_valid), .i_wb_ready(i_wb_ready),
    .in_ld(in_ld), .in_st(in_st), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_alu_res(in_alu_res), .in_st_data(in_st_data),
    .in_rf_waddr(in_rf_waddr), .in_rf_we(in_rf_we), .in_pc(in_pc), .in_inst(in_inst),
    .req(req), .req_wr(req_wr), .req_wstrb(req_wstrb), .req_addr(req_addr), .req_wdata(req_wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .mem_to_wb_rf_wdata(mem_to_wb_rf_wdata), .mem_to_wb_rf_waddr(mem_to_wb_rf_waddr),
    .mem_to_wb_rf_we(mem_to_wb_rf_we), .mem_to_wb_pc(mem_to_wb_pc), .mem_to_wb_inst(mem_to_wb_inst),
    .mem_to_wb_mem_re(mem_to_wb_mem_re),
`ifdef MEM_ALE_EN
    .mem_to_wb_ale(mem_to_wb_ale),
`endif
    .mem_busy(mem_busy)
  );

  mem_lsu #(.DW(64)) dut64 (
    .clk(clk), .rst(rst),
    .ex_to_mem_valid(w_ex_valid), .o_mem_ready(w_ready),
    .mem_to_wb_valid(w_valid), .i_wb_ready(w_wb_ready),
    .in_ld(w_ld), .in_st(w_st), .in_size(w_size), .in_unsigned(w_uns),
    .in_alu_res(w_alu), .in_st_data(w_sdata),
    .in_rf_waddr(w_waddr), .in_rf_we(w_we), .in_pc(w_pc), .in_inst(w_inst),
    .req(w_req), .req_wr(w_req_wr), .req_wstrb(w_wstrb), .req_addr(w_addr), .req_wdata(w_wdata),
    .addr_ok(w_addr_ok), .data_ok(w_data_ok), .rdata(w_rdata),
    .mem_to_wb_rf_wdata(w_rf_wdata), .mem_to_wb_rf_waddr(w_rf_waddr),
    .mem_to_wb_rf_we(w_rf_we), .mem_to_wb_pc(w_wb_pc), .mem_to_wb_inst(w_wb_inst),
    .mem_to_wb_mem_re(w_mem_re),
`ifdef MEM_ALE_EN
    .mem_to_wb_ale(w_ale),
`endif
    .mem_busy(w_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one op to the 32-bit DUT for a single cycle and record its result.
  task automatic issue32(input logic ld, input logic st, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rd,
                         input logic [31:0] e_wdata, input logic e_we, input logic e_re);
    exp_t e;
    @(negedge clk); #1;
    in_ld = ld; in_st = st; in_size = size; in_unsigned = uns;
    in_alu_res = addr; in_st_data = sdata; rdata = rd;
    in_rf_we = 1'b1; in_rf_waddr = 5'd3; in_pc = 32'h100; in_inst = 32'h13;
    ex_to_mem_valid = 1'b1;
    check("ready_at_issue", o_mem_ready, 1'b1);
    e.wdata = 64'(e_wdata); e.we = e_we; e.mem_re = e_re;
    sb32.push_back(e);
  endtask

  // Act as the SRAM (addr_ok after addr_dly REQ cycles, data_ok whenever busy)
  // until writeback valid; check request fields on every REQ cycle.
  task automatic run32(input string tag, input int exp_lat, input int addr_dly, input logic exp_req,
                       input logic [31:0] e_addr, input logic e_wr, input logic [3:0] e_strb,
                       input logic [31:0] e_wd);
    int   lat = 0;
    int   rc  = 0;
    logic seen = 1'b0;
    exp_t e;
    while (lat < 20) begin
      @(negedge clk); #1;
      ex_to_mem_valid = 1'b0;
      lat++;
      if (mem_to_wb_valid) break;
      if (req) begin
        check({tag, "_req_addr"}, req_addr, e_addr);
        check({tag, "_req_wr"}, req_wr, e_wr);
        check({tag, "_req_wstrb"}, req_wstrb, e_strb);
        check({tag, "_req_wdata"}, req_wdata, e_wd);
        seen    = 1'b1;
        addr_ok = (rc >= addr_dly);
        rc++;
      end else begin
        addr_ok = 1'b0;
      end
      data_ok = mem_busy;
    end
    addr_ok = 1'b0;
    data_ok = 1'b0;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_req_seen"}, seen, exp_req);
    if (mem_to_wb_valid && sb32.size() > 0) begin
      e = sb32.pop_front();
      check({tag, "_rf_wdata"}, mem_to_wb_rf_wdata, e.wdata);
      check({tag, "_rf_we"}, mem_to_wb_rf_we, e.we);
      check({tag, "_mem_re"}, mem_to_wb_mem_re, e.mem_re);
    end
  endtask

  task automatic issue64(input logic ld, input logic st, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] sdata, input logic [63:0] rd,
                         input logic [63:0] e_wdata, input logic e_we, input logic e_re);
    exp_t e;
    @(negedge clk); #1;
    w_ld = ld; w_st = st; w_size = size; w_uns = uns;
    w_alu = addr; w_sdata = sdata; w_rdata = rd;
    w_we = 1'b1; w_waddr = 5'd4; w_pc = 32'h200; w_inst = 32'h3;
    w_ex_valid = 1'b1;
    check("w_ready_at_issue", w_ready, 1'b1);
    e.wdata = e_wdata; e.we = e_we; e.mem_re = e_re;
    sb64.push_back(e);
  endtask

  task automatic run64(input string tag, input logic [7:0] e_strb, input logic [63:0] e_wd);
    int   lat = 0;
    exp_t e;
    while (lat < 20) begin
      @(negedge clk); #1;
      w_ex_valid = 1'b0;
      lat++;
      if (w_valid) break;
      if (w_req) begin
        check({tag, "_req_wstrb"}, w_wstrb, e_strb);
        check({tag, "_req_wdata"}, w_wdata, e_wd);
      end
      w_addr_ok = w_req;
      w_data_ok = w_busy;
    end
    w_addr_ok = 1'b0;
    w_data_ok = 1'b0;
    check({tag, "_latency"}, lat, 3);
    if (w_valid && sb64.size() > 0) begin
      e = sb64.pop_front();
      check({tag, "_rf_wdata"}, w_rf_wdata, e.wdata);
      check({tag, "_rf_we"}, w_rf_we, e.we);
      check({tag, "_mem_re"}, w_mem_re, e.mem_re);
    end
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    ex_to_mem_valid = 1'b0; i_wb_ready = 1'b1; in_ld = 1'b0; in_st = 1'b0; in_size = 2'd0;
    in_unsigned = 1'b0; in_alu_res = '0; in_st_data = '0; in_rf_waddr = '0; in_rf_we = 1'b0;
    in_pc = '0; in_inst = '0; addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
    w_ex_valid = 1'b0; w_wb_ready = 1'b1; w_ld = 1'b0; w_st = 1'b0; w_size = 2'd0; w_uns = 1'b0;
    w_alu = '0; w_sdata = '0; w_waddr = '0; w_we = 1'b0; w_pc = '0; w_inst = '0;
    w_addr_ok = 1'b0; w_data_ok = 1'b0; w_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", o_mem_ready, 1'b1);
    check("rst_req", req, 1'b0);
    check("rst_valid", mem_to_wb_valid, 1'b0);
    check("rst_rf_we", mem_to_wb_rf_we, 1'b0);
    check("rst_mem_re", mem_to_wb_mem_re, 1'b0);
    check("rst_busy", mem_busy, 1'b0);
    check("rst_rf_wdata", mem_to_wb_rf_wdata, 32'h0);
    check("rst_w_valid", w_valid, 1'b0);
    check("rst_w_req", w_req, 1'b0);
    rst = 1'b0;

    // Signed byte load from lane 3
    issue32(1, 0, 2'd0, 0, 32'h1003, 32'h0, 32'h80112233, 32'hFFFFFF80, 1, 1);
    run32("ldb", 3, 0, 1, 32'h1003, 0, 4'b0000, 32'h0);

    // Halfword store in upper lanes; slow addr_ok with data_ok held high in REQ
    issue32(0, 1, 2'd1, 0, 32'h2002, 32'h0000BEEF, 32'h0, 32'h2002, 0, 0);
    run32("sth", 5, 2, 1, 32'h2002, 1, 4'b1100, 32'hBEEFBEEF);

    // Halfword loads: zero-extended upper lane, sign-extended lower lane
    issue32(1, 0, 2'd1, 1, 32'h3002, 32'h0, 32'h80017FFF, 32'h00008001, 1, 1);
    run32("ldhu", 3, 0, 1, 32'h3002, 0, 4'b0000, 32'h0);
    issue32(1, 0, 2'd1, 0, 32'h3000, 32'h0, 32'h12348001, 32'hFFFF8001, 1, 1);
    run32("ldh", 3, 0, 1, 32'h3000, 0, 4'b0000, 32'h0);

    // Byte store replicated across all lanes
    issue32(0, 1, 2'd0, 0, 32'h5, 32'h123456A5, 32'h0, 32'h5, 0, 0);
    run32("stb", 3, 0, 1, 32'h5, 1, 4'b0010, 32'hA5A5A5A5);

    // Size 3 on a 32-bit bus acts as a word
    issue32(0, 1, 2'd3, 0, 32'h40, 32'hCAFEF00D, 32'h0, 32'h40, 0, 0);
    run32("std32", 3, 0, 1, 32'h40, 1, 4'b1111, 32'hCAFEF00D);
    issue32(1, 0, 2'd3, 0, 32'h44, 32'h0, 32'h87654321, 32'h87654321, 1, 1);
    run32("ldd32", 3, 0, 1, 32'h44, 0, 4'b0000, 32'h0);

`ifdef MEM_ALE_EN
    // Misaligned word load is flagged and never reaches the SRAM
    issue32(1, 0, 2'd2, 0, 32'h1002, 32'h0, 32'hAABBCCDD, 32'h0, 0, 1);
    run32("ldw_ale", 1, 0, 0, 32'h1002, 0, 4'b0000, 32'h0);
    check("ldw_ale_flag", mem_to_wb_ale, 1'b1);
`else
    // Misaligned accesses proceed; bytes beyond the bus are dropped
    issue32(1, 0, 2'd2, 0, 32'h1002, 32'h0, 32'hAABBCCDD, 32'h0000AABB, 1, 1);
    run32("ldw_mis", 3, 0, 1, 32'h1002, 0, 4'b0000, 32'h0);
    issue32(0, 1, 2'd2, 0, 32'h1001, 32'h11223344, 32'h0, 32'h1001, 0, 0);
    run32("stw_mis", 3, 0, 1, 32'h1001, 1, 4'b1110, 32'h11223344);
`endif

    // ALU op stalled by writeback for 4 cycles, then back-to-back accept
    @(negedge clk); #1;
    i_wb_ready = 1'b0;
    in_ld = 1'b0; in_st = 1'b0; in_alu_res = 32'h12345678; in_rf_we = 1'b1;
    in_rf_waddr = 5'd7; in_pc = 32'h400; in_inst = 32'h33;
    ex_to_mem_valid = 1'b1;
    check("alu_ready_at_issue", o_mem_ready, 1'b1);
    e.wdata = 64'h12345678; e.we = 1'b1; e.mem_re = 1'b0;
    sb32.push_back(e);
    @(negedge clk); #1;
    in_alu_res = 32'h9999; in_rf_waddr = 5'd9; in_pc = 32'h404;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk); #1;
      end
      check("stall_valid", mem_to_wb_valid, 1'b1);
      check("stall_ready", o_mem_ready, 1'b0);
      check("stall_wdata", mem_to_wb_rf_wdata, 32'h12345678);
      check("stall_waddr", mem_to_wb_rf_waddr, 5'd7);
      check("stall_pc", mem_to_wb_pc, 32'h400);
    end
    i_wb_ready = 1'b1;
    #1;
    check("release_ready", o_mem_ready, 1'b1);
    e = sb32.pop_front();
    check("release_wdata", mem_to_wb_rf_wdata, e.wdata);
    check("release_rf_we", mem_to_wb_rf_we, e.we);
    e.wdata = 64'h9999; e.we = 1'b1; e.mem_re = 1'b0;
    sb32.push_back(e);
    @(negedge clk); #1;
    ex_to_mem_valid = 1'b0;
    check("b2b_valid", mem_to_wb_valid, 1'b1);
    check("b2b_waddr", mem_to_wb_rf_waddr, 5'd9);
    check("b2b_pc", mem_to_wb_pc, 32'h404);
    e = sb32.pop_front();
    check("b2b_wdata", mem_to_wb_rf_wdata, e.wdata);
    check("b2b_mem_re", mem_to_wb_mem_re, e.mem_re);

    // Reset while waiting for data; a later data_ok must be ignored
    @(negedge clk); #1;
    in_ld = 1'b1; in_st = 1'b0; in_size = 2'd2; in_alu_res = 32'h8; rdata = 32'h55;
    ex_to_mem_valid = 1'b1;
    @(negedge clk); #1;
    ex_to_mem_valid = 1'b0;
    check("abort_in_req", req, 1'b1);
    addr_ok = 1'b1;
    @(negedge clk); #1;
    addr_ok = 1'b0;
    check("abort_in_wait", mem_busy & ~req, 1'b1);
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    check("abort_busy", mem_busy, 1'b0);
    check("abort_valid", mem_to_wb_valid, 1'b0);
    check("abort_mem_re", mem_to_wb_mem_re, 1'b0);
    check("abort_ready", o_mem_ready, 1'b1);
    data_ok = 1'b1;
    @(negedge clk); #1;
    data_ok = 1'b0;
    check("stray_valid", mem_to_wb_valid, 1'b0);
    check("stray_req", req, 1'b0);
    check("stray_busy", mem_busy, 1'b0);
    check("stray_rf_wdata", mem_to_wb_rf_wdata, 32'h0);

    // 64-bit datapath
    issue64(1, 0, 2'd2, 1, 64'h1004, 64'h0, 64'hDEADBEEF_00000000, 64'h00000000_DEADBEEF, 1, 1);
    run64("w_ldwu", 8'h00, 64'h0);
    issue64(0, 1, 2'd2, 0, 64'h1004, 64'h11223344, 64'h0, 64'h1004, 0, 0);
    run64("w_stw", 8'hF0, 64'h11223344_11223344);
    issue64(1, 0, 2'd3, 0, 64'h2000, 64'h0, 64'h80AA0000_00000000, 64'h80AA0000_00000000, 1, 1);
    run64("w_ldd", 8'h00, 64'h0);
    issue64(1, 0, 2'd0, 0, 64'h2007, 64'h0, 64'h80AA0000_00000000, 64'hFFFFFFFF_FFFFFF80, 1, 1);
    run64("w_ldb", 8'h00, 64'h0);

    check("sb32_empty", sb32.size(), 0);
    check("sb64_empty", sb64.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
